mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory: instruction-fetch (IF) read port and load/store (D) port.
- Grants at most one access per cycle and drives the memory's address, write data and strobes for the granted requester.
- The memory store is synchronous and its load path is combinational; this block registers the load result and returns it one cycle after grant.
- Sits between the core's fetch and LSU stages and the data memory. It makes a unified instruction/data memory shareable.

Parameters:
- PRIORITY_D, 0, 0 = round-robin on conflict; 1 = fixed priority, D port always wins.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- if_req  in  1  IF read request; held with stable if_addr until if_gnt
- if_addr  in  32  IF byte address
- if_gnt  out  1  IF granted this cycle (combinational)
- if_rvalid  out  1  IF read data valid (registered)
- if_rdata  out  32  IF read word (registered)
- d_req  in  1  D request; payload held stable until d_gnt
- d_addr  in  32  D byte address
- d_wdata  in  32  D store data
- d_sw  in  1  store word
- d_sb  in  1  store byte
- d_lw  in  1  load word
- d_lbu  in  1  load byte unsigned
- d_gnt  out  1  D granted this cycle (combinational)
- d_rvalid  out  1  D response valid (registered; pulses for stores too)
- d_rdata  out  32  D load result (registered; 0 for stores)
- m_addr  out  32  to memory addr
- m_write_data  out  32  to memory write_data
- m_sw, m_sb, m_lw, m_lbu  out  1 each  to memory strobes
- m_read_data  in  32  from memory read_data (combinational)
- conflict_cnt  out  CNT_W  saturating count of cycles where both requested

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - if_rvalid, d_rvalid, if_rdata, d_rdata, conflict_cnt all clear to 0.
  - The round-robin pointer sets to "IF next".
  - While rst_n=0, if_gnt, d_gnt and all m_* strobes are forced to 0, so no memory write can occur during reset.
- Arbitration (combinational, cycle N):
  - Only one request: grant it.
  - Both requests, PRIORITY_D=1: grant D.
  - Both requests, PRIORITY_D=0: grant the port selected by rr_ptr.
  - Neither request: no grant.
- rr_ptr update: on every grant, rr_ptr moves to point at the other port. rr_ptr is unchanged when there is no grant.
- Memory drive:
  - IF granted: m_addr=if_addr, m_lw=1, other strobes 0, m_write_data=0.
  - D granted: m_addr=d_addr, m_write_data=d_wdata, strobes pass through with priority sw>sb>lw>lbu. Exactly one strobe is asserted; none if the requester gave none.
  - No grant: m_addr=0, m_write_data=0, all strobes 0.
- Response (latency 1): at the edge ending cycle N, the granted port's rvalid<=1.
  - Its rdata<=m_read_data for loads; 0 for stores or when no strobe was set.
  - The ungranted port's rvalid<=0 and its rdata holds its previous value.
  - rvalid is a single-cycle pulse per grant.
- Throughput: back-to-back grants every cycle; no idle cycle required between accesses.
- Handshake rules:
  - A requester may deassert req only in the cycle after gnt.
  - A req held past gnt is a new request and is re-arbitrated.
  - A denied requester keeps req and payload stable.
  - A store is committed by the memory at the end of its grant cycle.
- Store-then-load hazard: a D store in cycle N followed by an IF or D load of the same word in N+1 returns the new data, because memory writes at the end of N.
- Starvation: in RR mode each port waits at most one cycle under continuous contention. In fixed mode IF may starve; this is accepted.
- conflict_cnt: increments by 1 on every cycle with if_req=1 and d_req=1 (and rst_n=1). It saturates at all-ones and does not wrap.
- Reset mid-operation: a pending response (grant in the cycle where reset asserts) is dropped, rvalid stays 0, and the requester must re-issue.

Test Plan:
- Reset: rst_n=0 for 2 cycles with if_req=d_req=1, d_sw=1 -> gnts=0, m_sw=0, memory unchanged, all outputs 0, conflict_cnt=0.
- Single IF: if_req=1, if_addr=0x10, mem[4]=0xDEADBEEF -> if_gnt=1 same cycle, m_lw=1; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- RR contention, PRIORITY_D=0: both req continuously for 4 cycles after reset -> grants IF,D,IF,D; conflict_cnt=4; each rvalid pulses on alternating cycles.
- Fixed priority, PRIORITY_D=1: both req for 3 cycles -> d_gnt=1 every cycle, if_gnt=0, if_rvalid never 1; conflict_cnt=3.
- Store/load and byte path: D sb addr 0x21 data 0xAB over word 0x11223344, then D lbu 0x21 -> d_rdata=0x000000AB; then lw 0x20 -> 0x1122AB44; store's d_rvalid pulse has d_rdata=0.
- Saturation, CNT_W=4: 20 contention cycles -> conflict_cnt=15 and held; assert rst_n=0 mid-stream with a grant pending -> rvalid 0 next cycle, counter 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch read port and a load/store port onto one single-port memory.
// One grant per cycle; the load result is registered and returned one cycle after the grant.
module mem_port_arbiter #(
    parameter bit          PRIORITY_D = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,

    input  logic             d_req,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    input  logic             d_sw,
    input  logic             d_sb,
    input  logic             d_lw,
    input  logic             d_lbu,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,

    output logic [31:0]      m_addr,
    output logic [31:0]      m_write_data,
    output logic             m_sw,
    output logic             m_sb,
    output logic             m_lw,
    output logic             m_lbu,
    input  logic [31:0]      m_read_data,

    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int unsigned DW = 32;

    logic          rr_d_next;
    logic          both_req;
    logic          is_load;
    logic [DW-1:0] load_data;

    assign both_req = if_req & d_req;

    // Grants are suppressed during reset so nothing reaches the memory.
    always_comb begin : arbitrate
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst_n) begin
            if (both_req) begin
                if (PRIORITY_D || rr_d_next) begin
                    d_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    // Route the winner onto the memory; D strobes are reduced to one with sw > sb > lw > lbu.
    always_comb begin : mem_drive
        m_addr       = '0;
        m_write_data = '0;
        m_sw         = 1'b0;
        m_sb         = 1'b0;
        m_lw         = 1'b0;
        m_lbu        = 1'b0;
        if (if_gnt) begin
            m_addr = if_addr;
            m_lw   = 1'b1;
        end else if (d_gnt) begin
            m_addr       = d_addr;
            m_write_data = d_wdata;
            if (d_sw) begin
                m_sw = 1'b1;
            end else if (d_sb) begin
                m_sb = 1'b1;
            end else if (d_lw) begin
                m_lw = 1'b1;
            end else if (d_lbu) begin
                m_lbu = 1'b1;
            end
        end
    end

    assign is_load   = m_lw | m_lbu;
    assign load_data = is_load ? m_read_data : '0;

    // rr_d_next=0 means IF wins the next conflict.
    always_ff @(posedge clk) begin : rr_update
        if (!rst_n) begin
            rr_d_next <= 1'b0;
        end else if (if_gnt) begin
            rr_d_next <= 1'b1;
        end else if (d_gnt) begin
            rr_d_next <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin : response
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt;
            if (if_gnt) begin
                if_rdata <= load_data;
            end
            if (d_gnt) begin
                d_rdata <= load_data;
            end
        end
    end

    always_ff @(posedge clk) begin : conflict_count
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (both_req && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 is round-robin with a 4-bit counter,
// instance 1 is fixed D priority with a 16-bit counter; each has its own behavioural memory.
module tb_mem_port_arbiter;

    localparam int NI    = 2;
    localparam int WORDS = 64;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n        [NI];
    logic        if_req       [NI];
    logic [31:0] if_addr      [NI];
    logic        if_gnt       [NI];
    logic        if_rvalid    [NI];
    logic [31:0] if_rdata     [NI];
    logic        d_req        [NI];
    logic [31:0] d_addr       [NI];
    logic [31:0] d_wdata      [NI];
    logic        d_sw         [NI];
    logic        d_sb         [NI];
    logic        d_lw         [NI];
    logic        d_lbu        [NI];
    logic        d_gnt        [NI];
    logic        d_rvalid     [NI];
    logic [31:0] d_rdata      [NI];
    logic [31:0] m_addr       [NI];
    logic [31:0] m_write_data [NI];
    logic [31:0] m_read_data  [NI];
    logic        m_sw         [NI];
    logic        m_sb         [NI];
    logic        m_lw         [NI];
    logic        m_lbu        [NI];
    logic [15:0] cnt_out      [NI];

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEAD_BEEF;
        if (i == 8) return 32'h1122_3344;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam bit PD = (g == 1);
        localparam int unsigned CW = (g == 0) ? 4 : 16;
        logic [CW-1:0] cnt;
        logic [31:0]   pmem [WORDS];
        logic [5:0]    widx;
        logic [1:0]    lane;

        mem_port_arbiter #(.PRIORITY_D(PD), .CNT_W(CW)) dut (
            .clk(clk), .rst_n(rst_n[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .d_req(d_req[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_sw(d_sw[g]), .d_sb(d_sb[g]), .d_lw(d_lw[g]), .d_lbu(d_lbu[g]),
            .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
            .m_addr(m_addr[g]), .m_write_data(m_write_data[g]),
            .m_sw(m_sw[g]), .m_sb(m_sb[g]), .m_lw(m_lw[g]), .m_lbu(m_lbu[g]),
            .m_read_data(m_read_data[g]),
            .conflict_cnt(cnt)
        );

        assign cnt_out[g] = 16'(cnt);
        assign widx = m_addr[g][7:2];
        assign lane = m_addr[g][1:0];
        assign m_read_data[g] = m_lbu[g] ? {24'h0, pmem[widx][int'(lane)*8 +: 8]} : pmem[widx];

        initial for (int i = 0; i < WORDS; i++) pmem[i] <= init_word(i);

        always @(posedge clk) begin
            if (m_sw[g]) pmem[widx] <= m_write_data[g];
            else if (m_sb[g]) pmem[widx][int'(lane)*8 +: 8] <= m_write_data[g][7:0];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [NI][WORDS];
    bit          last_d   [NI];
    int          cnt_m    [NI];
    bit          rst_seen [NI];
    bit          gi_m     [NI];
    bit          gd_m     [NI];
    resp_t       if_q[$];
    resp_t       d_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          sel = 0;

    function automatic void chk(string name, int k, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d got=%0h exp=%0h", name, k, cyc, got, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Predict grants, memory drive and counter for this cycle; queue the response for the next.
    task automatic eval(int k, bit rst_edge);
        bit          ei, ed;
        logic [31:0] ea, ew, ld;
        logic [3:0]  es;
        int          w, ln, cmax;
        ei = 1'b0;
        ed = 1'b0;
        if (rst_n[k]) begin
            if (if_req[k] && d_req[k]) begin
                if (k == 1 || !last_d[k]) ed = 1'b1;
                else ei = 1'b1;
            end else begin
                ei = if_req[k];
                ed = d_req[k];
            end
        end
        chk("if_gnt", k, 128'(if_gnt[k]), 128'(ei));
        chk("d_gnt", k, 128'(d_gnt[k]), 128'(ed));
        ea = '0; ew = '0; es = '0;
        if (ei) begin
            ea = if_addr[k];
            es = 4'b0010;
        end else if (ed) begin
            ea = d_addr[k];
            ew = d_wdata[k];
            if (d_sw[k]) es = 4'b1000;
            else if (d_sb[k]) es = 4'b0100;
            else if (d_lw[k]) es = 4'b0010;
            else if (d_lbu[k]) es = 4'b0001;
        end
        chk("m_bus", k, 128'({m_addr[k], m_write_data[k], m_sw[k], m_sb[k], m_lw[k], m_lbu[k]}),
            128'({ea, ew, es}));
        chk("conflict_cnt", k, 128'(cnt_out[k]), 128'(cnt_m[k]));
        if (rst_seen[k]) chk("rdata_after_rst", k, 128'({if_rdata[k], d_rdata[k]}), 128'(0));
        gi_m[k] = ei;
        gd_m[k] = ed;
        rst_seen[k] = rst_edge || !rst_n[k];
        if (rst_seen[k]) begin
            if (rst_edge) rst_n[k] = 1'b0;
            last_d[k] = 1'b1;
            cnt_m[k]  = 0;
        end else begin
            cmax = (k == 0) ? 15 : 65535;
            if (if_req[k] && d_req[k] && cnt_m[k] < cmax) cnt_m[k]++;
            if (ei) begin
                if_q.push_back('{cyc + 1, ref_mem[k][int'(if_addr[k][7:2])]});
                last_d[k] = 1'b0;
            end
            if (ed) begin
                w  = int'(d_addr[k][7:2]);
                ln = int'(d_addr[k][1:0]);
                ld = 32'h0;
                if (es == 4'b0010) ld = ref_mem[k][w];
                else if (es == 4'b0001) ld = {24'h0, ref_mem[k][w][ln*8 +: 8]};
                else if (es == 4'b1000) ref_mem[k][w] = d_wdata[k];
                else if (es == 4'b0100) ref_mem[k][w][ln*8 +: 8] = d_wdata[k][7:0];
                d_q.push_back('{cyc + 1, ld});
                last_d[k] = 1'b1;
            end
        end
    endtask

    task automatic tick(bit rst0, bit rst1);
        @(negedge clk);
        eval(0, rst0);
        eval(1, rst1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle(int k);
        if_req[k] = 1'b0; if_addr[k] = '0;
        d_req[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        d_sw[k] = 1'b0; d_sb[k] = 1'b0; d_lw[k] = 1'b0; d_lbu[k] = 1'b0;
    endtask

    task automatic rand_d(int k);
        int r;
        r = int'($urandom_range(0, 9));
        d_addr[k]  = 32'($urandom_range(0, 255));
        d_wdata[k] = $urandom;
        {d_sw[k], d_sb[k], d_lw[k], d_lbu[k]} = 4'b0000;
        case (r)
            0, 1:    d_sw[k] = 1'b1;
            2, 3:    d_sb[k] = 1'b1;
            4, 5:    d_lw[k] = 1'b1;
            6, 7:    d_lbu[k] = 1'b1;
            8:       ;
            default: {d_sw[k], d_sb[k], d_lw[k], d_lbu[k]} = 4'($urandom);
        endcase
    endtask

    // A denied requester holds; otherwise it issues a fresh random request.
    task automatic next_inputs(int k, int pct_if, int pct_d);
        if (!(if_req[k] && !gi_m[k])) begin
            if_req[k]  = (int'($urandom_range(0, 99)) < pct_if);
            if_addr[k] = 32'($urandom_range(0, 255));
        end
        if (!(d_req[k] && !gd_m[k])) begin
            d_req[k] = (int'($urandom_range(0, 99)) < pct_d);
            rand_d(k);
        end
    endtask

    task automatic set_d(int k, logic [31:0] a, logic [31:0] wd, logic [3:0] op);
        d_req[k] = 1'b1; d_addr[k] = a; d_wdata[k] = wd;
        {d_sw[k], d_sb[k], d_lw[k], d_lbu[k]} = op;
    endtask

    always @(posedge clk) begin
        resp_t it;
        #2;
        if (if_q.size() > 0 && if_q[0].due == cyc) begin
            it = if_q.pop_front();
            chk("if_resp", sel, 128'({if_rvalid[sel], if_rdata[sel]}), 128'({1'b1, it.data}));
        end else begin
            chk("if_rvalid_idle", sel, 128'(if_rvalid[sel]), 128'(0));
        end
        if (d_q.size() > 0 && d_q[0].due == cyc) begin
            it = d_q.pop_front();
            chk("d_resp", sel, 128'({d_rvalid[sel], d_rdata[sel]}), 128'({1'b1, it.data}));
        end else begin
            chk("d_rvalid_idle", sel, 128'(d_rvalid[sel]), 128'(0));
        end
        chk("other_rvalid", 1 - sel, 128'({if_rvalid[1 - sel], d_rvalid[1 - sel]}), 128'(0));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            set_idle(k);
            rst_n[k] = 1'b0;
            if_req[k] = 1'b1; if_addr[k] = 32'h10;
            set_d(k, 32'h10, 32'hFFFF_FFFF, 4'b1000);
            last_d[k] = 1'b1;
            for (int i = 0; i < WORDS; i++) ref_mem[k][i] = init_word(i);
        end
        tick(0, 0);
        tick(0, 0);
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b1;
            set_idle(k);
        end
        tick(0, 0);

        // Round-robin instance: contention, single IF, byte store/load
        sel = 0;
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        set_d(0, 32'h20, 32'h0, 4'b0010);
        repeat (4) tick(0, 0);
        set_idle(0);
        tick(0, 0);
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        tick(0, 0);
        set_idle(0);
        tick(0, 0);
        set_d(0, 32'h21, 32'h0000_00AB, 4'b0100);
        tick(0, 0);
        set_d(0, 32'h21, 32'h0, 4'b0001);
        tick(0, 0);
        set_d(0, 32'h20, 32'h0, 4'b0010);
        tick(0, 0);
        set_idle(0);
        tick(0, 0);
        repeat (400) begin
            next_inputs(0, 70, 70);
            tick(0, 0);
        end
        repeat (4) begin
            next_inputs(0, 0, 0);
            tick(0, 0);
        end
        set_idle(0);
        tick(0, 0);

        // Counter saturation, then reset with a grant in flight
        if_req[0] = 1'b1; if_addr[0] = 32'h34;
        set_d(0, 32'h30, 32'h0, 4'b0010);
        repeat (20) tick(0, 0);
        tick(1, 0);
        rst_n[0] = 1'b1;
        set_idle(0);
        tick(0, 0);
        tick(0, 0);

        // Fixed-priority instance
        sel = 1;
        if_req[1] = 1'b1; if_addr[1] = 32'h10;
        set_d(1, 32'h20, 32'h0, 4'b0010);
        repeat (3) tick(0, 0);
        set_idle(1);
        tick(0, 0);
        repeat (400) begin
            next_inputs(1, 70, 70);
            tick(0, 0);
        end
        repeat (6) begin
            next_inputs(1, 0, 0);
            tick(0, 0);
        end
        set_idle(1);
        tick(0, 0);
        tick(0, 0);

        chk("if_q_drained", sel, 128'(if_q.size()), 128'(0));
        chk("d_q_drained", sel, 128'(d_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
